opl_timer_bank: RTL and testbench

- Parametrised bank of N independent OPL-style up-counting timers with a shared tick prescaler base, per-channel mask, sticky status flags and a combined IRQ output.
- Generalises the single-timer block: configurable channel count, counter width and per-channel tick period (channel k runs 2^(k*TICK_SHIFT) times slower than channel 0).
- Adds one-cycle overflow pulses, flag/IRQ generation and flag clear.
- Sits between the register file (timer init/control registers) and the host status/IRQ path.

---
 rtl/opl_timer_pkg.sv | 16 +
 rtl/opl_timer_channel.sv | 55 +++++
 rtl/opl_timer_bank.sv | 61 ++++++
 tb/tb_opl_timer_bank.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/opl_timer_pkg.sv
// Shared defaults and tick-period helper for the OPL timer bank.
package opl_timer_pkg;

  localparam int unsigned DEFAULT_NUM_TIMERS      = 2;
  localparam int unsigned DEFAULT_TIMER_WIDTH     = 8;
  localparam int unsigned DEFAULT_BASE_TICK_COUNT = 4000;
  localparam int unsigned DEFAULT_TICK_SHIFT      = 2;

  // Channel k runs 2^(k*shift) times slower than channel 0.
  function automatic int unsigned tick_period(input int unsigned base,
                                              input int unsigned shift,
                                              input int unsigned k);
    return base << (k * shift);
  endfunction

endpackage

// File: rtl/opl_timer_channel.sv
// One OPL-style up-counting timer: start-edge load, tick prescaler, counter and
// registered overflow pulse. The wrap output flags an overflow on the coming edge.
module opl_timer_channel #(
  parameter int unsigned TIMER_WIDTH = 8,
  parameter int unsigned TICK_COUNT  = 4000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [TIMER_WIDTH-1:0] init,
  input  logic                   start,
  output logic                   overflow_pulse,
  output logic                   wrap
);

  localparam int unsigned          PRE_W    = $clog2(TICK_COUNT);
  localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(TICK_COUNT - 1);
  localparam logic [TIMER_WIDTH-1:0] CNT_MAX = '1;

  logic                   start_p1;
  logic [PRE_W-1:0]       prescaler;
  logic [TIMER_WIDTH-1:0] counter;
  logic                   load;
  logic                   run;
  logic                   tick;

  assign load = start & ~start_p1;
  assign run  = start & start_p1;
  assign tick = run && (prescaler == PRE_LAST);
  assign wrap = tick && (counter == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_p1       <= 1'b0;
      prescaler      <= '0;
      counter        <= '0;
      overflow_pulse <= 1'b0;
    end else begin
      start_p1       <= start;
      overflow_pulse <= wrap;
      if (load) begin
        counter   <= init;
        prescaler <= '0;
      end else if (run) begin
        if (tick) begin
          prescaler <= '0;
          // init is sampled only here and at load, so mid-run edits wait for the wrap
          counter   <= (counter == CNT_MAX) ? init : counter + TIMER_WIDTH'(1);
        end else begin
          prescaler <= prescaler + PRE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/opl_timer_bank.sv
// Bank of independent OPL timers with per-channel mask, sticky flags and a
// combined IRQ that rises in the same cycle as the flag.
module opl_timer_bank
  import opl_timer_pkg::*;
#(
  parameter int unsigned NUM_TIMERS      = DEFAULT_NUM_TIMERS,
  parameter int unsigned TIMER_WIDTH     = DEFAULT_TIMER_WIDTH,
  parameter int unsigned BASE_TICK_COUNT = DEFAULT_BASE_TICK_COUNT,
  parameter int unsigned TICK_SHIFT      = DEFAULT_TICK_SHIFT
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_TIMERS*TIMER_WIDTH-1:0] init,
  input  logic [NUM_TIMERS-1:0]             start,
  input  logic [NUM_TIMERS-1:0]             mask,
  input  logic                              flag_clear,
  output logic [NUM_TIMERS-1:0]             overflow_pulse,
  output logic [NUM_TIMERS-1:0]             flags,
  output logic                              irq
);

  logic [NUM_TIMERS-1:0] wrap;
  logic [NUM_TIMERS-1:0] flags_nxt;

  for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_ch
    localparam int unsigned PERIOD = tick_period(BASE_TICK_COUNT, TICK_SHIFT, k);

    opl_timer_channel #(
      .TIMER_WIDTH (TIMER_WIDTH),
      .TICK_COUNT  (PERIOD)
    ) u_ch (
      .clk            (clk),
      .reset_n        (reset_n),
      .init           (init[k*TIMER_WIDTH +: TIMER_WIDTH]),
      .start          (start[k]),
      .overflow_pulse (overflow_pulse[k]),
      .wrap           (wrap[k])
    );
  end

  // A new overflow outranks flag_clear so no event is lost; mask outranks both.
  always_comb begin
    flags_nxt = flags;
    for (int k = 0; k < NUM_TIMERS; k++) begin
      if (mask[k])         flags_nxt[k] = 1'b0;
      else if (wrap[k])    flags_nxt[k] = 1'b1;
      else if (flag_clear) flags_nxt[k] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags <= '0;
      irq   <= 1'b0;
    end else begin
      flags <= flags_nxt;
      irq   <= |flags_nxt;
    end
  end

endmodule

// File: tb/tb_opl_timer_bank.sv
// Directed bench for opl_timer_bank: pulse scoreboard plus flag/IRQ/counter checks.
module tb_opl_timer_bank;

  logic        clk;
  logic        reset_n;
  logic [15:0] init;
  logic [1:0]  start;
  logic [1:0]  mask;
  logic        flag_clear;
  logic [1:0]  overflow_pulse;
  logic [1:0]  flags;
  logic        irq;
  logic [7:0]  cnt0;

  int edge_n = 0;
  int checks = 0;
  int errors = 0;
  int exp_q0[$];
  int exp_q1[$];
  int e0, e1, e2;

  opl_timer_bank #(
    .NUM_TIMERS      (2),
    .TIMER_WIDTH     (8),
    .BASE_TICK_COUNT (4),
    .TICK_SHIFT      (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .init           (init),
    .start          (start),
    .mask           (mask),
    .flag_clear     (flag_clear),
    .overflow_pulse (overflow_pulse),
    .flags          (flags),
    .irq            (irq)
  );

  assign cnt0 = dut.g_ch[0].u_ch.counter;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: each pulse must match the front of its channel's expected-edge queue.
  always @(negedge clk) begin
    while (exp_q0.size() > 0 && exp_q0[0] < edge_n) begin
      checks++; errors++;
      $display("FAIL pulse0_missing: got none expected pulse at edge %0d", exp_q0.pop_front());
    end
    while (exp_q1.size() > 0 && exp_q1[0] < edge_n) begin
      checks++; errors++;
      $display("FAIL pulse1_missing: got none expected pulse at edge %0d", exp_q1.pop_front());
    end
    if (overflow_pulse[0] === 1'b1) begin
      checks++;
      if (exp_q0.size() > 0 && exp_q0[0] == edge_n) void'(exp_q0.pop_front());
      else begin
        errors++;
        $display("FAIL pulse0_unexpected: got pulse at edge %0d expected none", edge_n);
      end
    end
    if (overflow_pulse[1] === 1'b1) begin
      checks++;
      if (exp_q1.size() > 0 && exp_q1[0] == edge_n) void'(exp_q1.pop_front());
      else begin
        errors++;
        $display("FAIL pulse1_unexpected: got pulse at edge %0d expected none", edge_n);
      end
    end
  end

  initial begin
    reset_n = 1'b0; init = '0; start = '0; mask = '0; flag_clear = 1'b0;
    step(3);
    chk("rst_pulse", 32'(overflow_pulse), 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_irq",   32'(irq), 32'h0);
    reset_n = 1'b1;
    step(2);

    // Channel 0, init 0xFE: tick every 4 edges, wrap every 8.
    init[7:0] = 8'hFE; start[0] = 1'b1; e0 = edge_n + 1;
    for (int i = 1; i <= 4; i++) exp_q0.push_back(e0 + 8 * i);
    step(5);
    chk("ch0_cnt_ff", 32'(cnt0), 32'hFF);
    step(4);
    chk("ch0_flag_set", 32'(flags), 32'h1);
    chk("ch0_irq_set",  32'(irq), 32'h1);
    chk("ch0_reload",   32'(cnt0), 32'hFE);

    step(7);
    flag_clear = 1'b1;                    // coincides with wrap at e0+16
    step(1);
    chk("set_beats_clear", 32'(flags), 32'h1);
    step(1);
    chk("clear_flags", 32'(flags), 32'h0);
    chk("clear_irq",   32'(irq), 32'h0);
    flag_clear = 1'b0; mask[0] = 1'b1;

    step(7);                              // wrap at e0+24 while masked
    chk("mask_flags", 32'(flags), 32'h0);
    chk("mask_irq",   32'(irq), 32'h0);
    mask[0] = 1'b0;
    step(8);                              // wrap at e0+32 unmasked
    chk("unmask_flags", 32'(flags), 32'h1);
    chk("unmask_irq",   32'(irq), 32'h1);
    mask[0] = 1'b1;
    step(1);
    chk("mask_clr_flags", 32'(flags), 32'h0);
    chk("mask_clr_irq",   32'(irq), 32'h0);
    mask[0] = 1'b0; start[0] = 1'b0;

    step(20);
    chk("stop_hold_cnt", 32'(cnt0), 32'hFE);
    init[7:0] = 8'h10; start[0] = 1'b1;
    step(1);
    chk("restart_load", 32'(cnt0), 32'h10);
    start[0] = 1'b0;
    step(2);

    // Channel 1, init 0xFF: tick and wrap every 16 edges.
    init[15:8] = 8'hFF; start[1] = 1'b1; e1 = edge_n + 1;
    for (int i = 1; i <= 3; i++) exp_q1.push_back(e1 + 16 * i);
    step(16);
    chk("ch0_idle_cnt", 32'(cnt0), 32'h10);
    init[7:0] = 8'hFF; start[0] = 1'b1;   // ch0 all-ones: wrap every tick
    for (int i = 0; i < 8; i++) exp_q0.push_back(e1 + 20 + 4 * i);
    step(1);
    chk("ch1_flags", 32'(flags), 32'h2);
    chk("ch1_irq",   32'(irq), 32'h1);
    chk("ch0_load_ff", 32'(cnt0), 32'hFF);
    flag_clear = 1'b1;
    step(1);
    chk("clear_both", 32'(flags), 32'h0);
    chk("clear_both_irq", 32'(irq), 32'h0);
    flag_clear = 1'b0;
    step(15);
    chk("simul_flags", 32'(flags), 32'h3);
    step(16);
    chk("simul_flags2", 32'(flags), 32'h3);

    // Asynchronous reset between edges, just after a pulse edge.
    #1 reset_n = 1'b0; start = '0;
    #1;
    chk("async_pulse", 32'(overflow_pulse), 32'h0);
    chk("async_flags", 32'(flags), 32'h0);
    chk("async_irq",   32'(irq), 32'h0);
    chk("async_cnt",   32'(cnt0), 32'h0);
    step(3);
    chk("held_flags", 32'(flags), 32'h0);
    chk("held_pulse", 32'(overflow_pulse), 32'h0);
    reset_n = 1'b1;
    step(20);
    chk("post_rst_flags", 32'(flags), 32'h0);

    init[7:0] = 8'hFF; start[0] = 1'b1; e2 = edge_n + 1;
    exp_q0.push_back(e2 + 4);
    step(5);
    chk("fresh_flags", 32'(flags), 32'h1);
    chk("fresh_irq",   32'(irq), 32'h1);
    start[0] = 1'b0;
    step(4);

    chk("q0_drained", 32'(exp_q0.size()), 32'h0);
    chk("q1_drained", 32'(exp_q1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
